rw_burst_ctrl: RTL and testbench

Parametrised read/write burst controller sitting between a client request port and a single-port memory/peripheral bus. It accepts one command (direction, start address, beat count) per transaction and sequences IDLE → WRITE/READ → DONE like the existing read/write FSM. It adds multi-beat bursts with incrementing address, per-beat memory acknowledge, a write-data handshake, read-data return and an acknowledge timeout with error reporting.

---
 rtl/rw_pkg.sv | 20 ++
 rtl/rw_burst_ctrl_if.sv | 51 +++++
 rtl/rw_wait_timer.sv | 41 ++++
 rtl/rw_burst_ctrl.sv | 147 ++++++++++++++
 tb/tb_rw_burst_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rw_pkg.sv
// Shared types and constants for the read/write burst controller.
package rw_pkg;

  // Controller states; encodings are visible on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Default number of unacknowledged access cycles before a beat is abandoned.
  localparam int unsigned DEFAULT_TIMEOUT = 15;

  // Width of a counter able to hold 0..limit, never less than one bit.
  function automatic int unsigned timer_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rw_burst_ctrl_if.sv
// Client command/data port and memory bus of the burst controller.
//
// Handshake rule for req_* and wdata_*: a transfer happens on the rising edge
// where both valid and ready are high; the source may not retract payload
// while valid is high and not yet taken; ready may depend on state only.
// Memory side: mem_en/mem_we/mem_addr/mem_wdata stay stable until a rising
// edge samples mem_ack high; mem_ack with mem_en low is ignored.
interface rw_burst_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 2
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              exec;
  logic              rd_wr;
  logic              done;
  logic              err;

  // Controller view.
  modport slave (
    input  req_valid, req_write, req_addr, req_len,
    input  wdata_valid, wdata, mem_rdata, mem_ack,
    output req_ready, wdata_ready, rdata_valid, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output exec, rd_wr, done, err
  );

  // Client plus memory view.
  modport master (
    output req_valid, req_write, req_addr, req_len,
    output wdata_valid, wdata, mem_rdata, mem_ack,
    input  req_ready, wdata_ready, rdata_valid, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  exec, rd_wr, done, err
  );
endinterface

// File: rtl/rw_wait_timer.sv
// Counts consecutive cycles an access waits for its acknowledge.
module rw_wait_timer
  import rw_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned CW = timer_width(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise advance while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Expiry fires during the LIMIT-th waiting cycle; LIMIT of zero disables it.
  always_comb begin
    expired = (LIMIT != 0) && en && (cnt_q == LAST);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/rw_burst_ctrl.sv
// Read/write burst controller: one command per transaction, incrementing
// address per beat, per-beat memory acknowledge with timeout abort.
module rw_burst_ctrl
  import rw_pkg::*;
#(
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 8,
  parameter int          LEN_W   = 2,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  rw_burst_ctrl_if.slave  bus,
  output state_t          dbg_state
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;      // beats remaining after the current one
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              mem_en_q, mem_en_d;
  logic              rd_wr_q, rd_wr_d;
  logic              err_q, err_d;

  logic accept, beat_ack, tmr_en, tmo_expired;

  assign accept   = bus.req_valid && bus.req_ready;
  assign beat_ack = mem_en_q && bus.mem_ack;
  assign tmr_en   = mem_en_q && !bus.mem_ack;

  rw_wait_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (!tmr_en),
    .en      (tmr_en),
    .expired (tmo_expired)
  );

  // Next-state, address, beat and data-path decisions.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    mem_en_d      = mem_en_q;
    rd_wr_d       = rd_wr_q;
    err_d         = err_q;
    case (state_q)
      ST_IDLE: begin
        mem_en_d = 1'b0;
        if (accept) begin
          addr_d  = bus.req_addr;
          len_d   = bus.req_len;
          rd_wr_d = bus.req_write;
          err_d   = 1'b0;
          if (bus.req_write) begin
            state_d = ST_WRITE;
          end else begin
            // Reads start their first access on the accepting edge.
            state_d  = ST_READ;
            mem_en_d = 1'b1;
          end
        end
      end
      ST_WRITE, ST_READ: begin
        if (!mem_en_q) begin
          // Idle gap between beats: reads relaunch, writes wait for data.
          if (state_q == ST_READ) begin
            mem_en_d = 1'b1;
          end else if (bus.wdata_valid) begin
            wdata_d  = bus.wdata;
            mem_en_d = 1'b1;
          end
        end else if (beat_ack) begin
          mem_en_d = 1'b0;
          addr_d   = addr_q + ADDR_W'(1);
          if (state_q == ST_READ) begin
            rdata_d       = bus.mem_rdata;
            rdata_valid_d = 1'b1;
          end
          if (len_q == '0) begin
            state_d = ST_DONE;
          end else begin
            len_d = len_q - LEN_W'(1);
          end
        end else if (tmo_expired) begin
          // Abandon the rest of the burst.
          mem_en_d = 1'b0;
          err_d    = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        mem_en_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        mem_en_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      mem_en_q      <= 1'b0;
      rd_wr_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      mem_en_q      <= mem_en_d;
      rd_wr_q       <= rd_wr_d;
      err_q         <= err_d;
    end
  end

  assign bus.req_ready   = (state_q == ST_IDLE) && !reset;
  assign bus.wdata_ready = (state_q == ST_WRITE) && !mem_en_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.rdata       = rdata_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_en_q && rd_wr_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.exec        = (state_q == ST_DONE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.rd_wr       = rd_wr_q;
  assign bus.err         = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_rw_burst_ctrl.sv
// Bench for rw_burst_ctrl: memory/client environment, burst reference model.
module tb_rw_burst_ctrl;
  import rw_pkg::*;

  localparam int          ADDR_W  = 8;
  localparam int          DATA_W  = 8;
  localparam int          LEN_W   = 2;
  localparam int unsigned TIMEOUT = 15;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rw_burst_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  rw_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- environment state ----------------
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  logic [7:0] mem_arr [256];   // the attached memory
  logic [7:0] ref_mem [256];   // reference model's view of memory

  int   ack_wait = 0;
  bit   ack_never = 1'b0;
  bit   spurious_ack = 1'b0;
  int   stall_gap = 0;
  int   wait_cnt = 0;
  int   stall_cnt = 0;
  bit   wd_taken = 1'b0;

  logic [7:0] wd_q[$];
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [7:0] rd_addr_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rdv_q[$];
  int         done_cyc_q[$];
  logic       last_err;
  logic       last_rd_wr;
  int         en_cycles = 0;

  // Memory responder, write-data source and output monitor, all at negedge.
  initial begin
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    forever begin
      @(negedge clk);
      if (bus.rdata_valid) rdv_q.push_back(bus.rdata);
      if (bus.done) begin
        done_cyc_q.push_back(cyc);
        last_err   = bus.err;
        last_rd_wr = bus.rd_wr;
      end
      if (bus.mem_en) en_cycles++;
      if (bus.mem_en && !ack_never && wait_cnt >= ack_wait) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_arr[bus.mem_addr];
        if (bus.mem_we) begin
          mem_arr[bus.mem_addr] = bus.mem_wdata;
          wr_addr_q.push_back(bus.mem_addr);
          wr_data_q.push_back(bus.mem_wdata);
        end else begin
          rd_addr_q.push_back(bus.mem_addr);
        end
        wait_cnt = 0;
      end else begin
        bus.mem_ack   = spurious_ack && !bus.mem_en;
        bus.mem_rdata = 8'($urandom);
        if (bus.mem_en) wait_cnt++;
        else wait_cnt = 0;
      end
      if (wd_taken && wd_q.size() > 0) begin
        wd_q.delete(0);
        stall_cnt = stall_gap;
      end
      wd_taken = 1'b0;
      if (wd_q.size() > 0 && stall_cnt == 0) begin
        bus.wdata_valid = 1'b1;
        bus.wdata       = wd_q[0];
      end else begin
        bus.wdata_valid = 1'b0;
        if (stall_cnt > 0) stall_cnt--;
      end
      wd_taken = bus.wdata_valid && bus.wdata_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    rdv_q.delete();
    done_cyc_q.delete();
    en_cycles = 0;
  endtask

  // Present a command and hold it until accepted; acc = cycle of acceptance.
  task automatic issue_cmd(input bit w, input logic [7:0] a, input logic [1:0] l,
                           output int acc, output bit ok);
    int budget;
    budget = 300;
    ok  = 1'b0;
    acc = -1;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_len   = l;
    while (budget > 0) begin
      if (bus.req_ready) begin
        acc = cyc;
        ok  = 1'b1;
        break;
      end
      step();
      budget--;
    end
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    while (done_cyc_q.size() < n && budget > 0) begin
      step();
      budget--;
    end
    chk_cnt++; if (done_cyc_q.size() < n) $display("FAIL wait_done: got %0d done pulses want %0d", done_cyc_q.size(), n); else pass_cnt++;
  endtask

  // One complete burst checked against the spec-level model.
  task automatic run_burst(input bit w, input logic [7:0] a, input logic [1:0] l,
                           input int wt, input int st, input int dbase, input string name);
    logic [7:0] d[$];
    int beats, acc, exp_done, hs;
    bit ok;
    beats     = int'(l) + 1;
    ack_wait  = wt;
    stall_gap = st;
    repeat (6) step();
    clear_obs();
    exp_q.delete();
    for (int i = 0; i < beats; i++) d.push_back((dbase >= 0) ? 8'(dbase + i) : 8'($urandom));
    if (w) for (int i = 0; i < beats; i++) wd_q.push_back(d[i]);
    else for (int i = 0; i < beats; i++) exp_q.push_back(ref_mem[8'(a + 8'(i))]);
    issue_cmd(w, a, l, acc, ok);
    chk_cnt++; if (!ok) $display("FAIL %s accept: got 0 want 1", name); else pass_cnt++;
    wait_done(1, 400);
    repeat (2) step();
    if (w) begin
      hs = 1;
      for (int i = 1; i < beats; i++) hs = (hs + 2 + wt > hs + 1 + st) ? hs + 2 + wt : hs + 1 + st;
      exp_done = acc + hs + wt + 2;
    end else begin
      exp_done = acc + beats * (wt + 2);
    end
    chk_cnt++; if (done_cyc_q.size() != 1) $display("FAIL %s done_count: got %0d want 1", name, done_cyc_q.size()); else pass_cnt++;
    if (done_cyc_q.size() > 0) begin
      chk_cnt++; if (done_cyc_q[0] != exp_done) $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc_q[0], exp_done); else pass_cnt++;
    end
    chk_cnt++; if (last_err !== 1'b0) $display("FAIL %s err: got %b want 0", name, last_err); else pass_cnt++;
    chk_cnt++; if (last_rd_wr !== w) $display("FAIL %s rd_wr: got %b want %b", name, last_rd_wr, w); else pass_cnt++;
    chk_cnt++; if (bus.rd_wr !== w) $display("FAIL %s rd_wr_idle: got %b want %b", name, bus.rd_wr, w); else pass_cnt++;
    chk_cnt++; if (en_cycles != beats * (wt + 1)) $display("FAIL %s mem_en_cycles: got %0d want %0d", name, en_cycles, beats * (wt + 1)); else pass_cnt++;
    if (w) begin
      chk_cnt++; if (wr_addr_q.size() != beats) $display("FAIL %s write_count: got %0d want %0d", name, wr_addr_q.size(), beats); else pass_cnt++;
      for (int i = 0; i < beats && i < wr_addr_q.size(); i++) begin
        chk_cnt++; if (wr_addr_q[i] !== 8'(a + 8'(i))) $display("FAIL %s write_addr[%0d]: got %h want %h", name, i, wr_addr_q[i], 8'(a + 8'(i))); else pass_cnt++;
        chk_cnt++; if (wr_data_q[i] !== d[i]) $display("FAIL %s write_data[%0d]: got %h want %h", name, i, wr_data_q[i], d[i]); else pass_cnt++;
      end
      for (int i = 0; i < beats; i++) ref_mem[8'(a + 8'(i))] = d[i];
    end else begin
      chk_cnt++; if (rdv_q.size() != beats) $display("FAIL %s rdata_count: got %0d want %0d", name, rdv_q.size(), beats); else pass_cnt++;
      for (int i = 0; i < beats && i < rdv_q.size() && i < rd_addr_q.size(); i++) begin
        chk_cnt++; if (rd_addr_q[i] !== 8'(a + 8'(i))) $display("FAIL %s read_addr[%0d]: got %h want %h", name, i, rd_addr_q[i], 8'(a + 8'(i))); else pass_cnt++;
        chk_cnt++; if (rdv_q[i] !== exp_q[i]) $display("FAIL %s rdata[%0d]: got %h want %h", name, i, rdv_q[i], exp_q[i]); else pass_cnt++;
      end
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    repeat (3) step();
    chk_cnt++; if (bus.req_ready !== 1'b0) $display("FAIL reset req_ready: got %b want 0", bus.req_ready); else pass_cnt++;
    chk_cnt++; if ({bus.mem_en, bus.mem_we, bus.wdata_ready, bus.rdata_valid, bus.exec, bus.done, bus.err, bus.rd_wr} !== 8'h00)
      $display("FAIL reset flags: got %b want 00000000", {bus.mem_en, bus.mem_we, bus.wdata_ready, bus.rdata_valid, bus.exec, bus.done, bus.err, bus.rd_wr}); else pass_cnt++;
    chk_cnt++; if ({bus.mem_addr, bus.mem_wdata, bus.rdata} !== 24'h0) $display("FAIL reset buses: got %h want 000000", {bus.mem_addr, bus.mem_wdata, bus.rdata}); else pass_cnt++;
    chk_cnt++; if (dbg_state !== ST_IDLE) $display("FAIL reset state: got %0d want 0", dbg_state); else pass_cnt++;
    reset = 1'b0;
    step();
    chk_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL idle req_ready: got %b want 1", bus.req_ready); else pass_cnt++;
  endtask

  task automatic test_write_burst();
    run_burst(1'b1, 8'h10, 2'd3, 0, 0, 'hA0, "write_a0");
  endtask

  task automatic test_read_wrap();
    run_burst(1'b0, 8'hFE, 2'd2, 2, 0, -1, "read_wrap");
  endtask

  task automatic test_write_stall();
    run_burst(1'b1, 8'($urandom), 2'd3, 0, 5, -1, "write_stall");
  endtask

  task automatic test_single_read();
    run_burst(1'b0, 8'($urandom), 2'd0, 0, 0, -1, "read_one");
  endtask

  task automatic test_timeout();
    int acc;
    bit ok;
    logic [7:0] a;
    a = 8'($urandom);
    repeat (4) step();
    ack_never = 1'b1;
    clear_obs();
    issue_cmd(1'b0, a, 2'd3, acc, ok);
    wait_done(1, 100);
    repeat (2) step();
    chk_cnt++; if (en_cycles != TIMEOUT) $display("FAIL timeout mem_en_cycles: got %0d want %0d", en_cycles, TIMEOUT); else pass_cnt++;
    if (done_cyc_q.size() > 0) begin
      chk_cnt++; if (done_cyc_q[0] != acc + int'(TIMEOUT) + 1) $display("FAIL timeout done_cycle: got %0d want %0d", done_cyc_q[0], acc + int'(TIMEOUT) + 1); else pass_cnt++;
    end
    chk_cnt++; if (last_err !== 1'b1) $display("FAIL timeout err_at_done: got %b want 1", last_err); else pass_cnt++;
    chk_cnt++; if (rdv_q.size() != 0) $display("FAIL timeout rdata_count: got %0d want 0", rdv_q.size()); else pass_cnt++;
    chk_cnt++; if (bus.err !== 1'b1) $display("FAIL timeout err_held: got %b want 1", bus.err); else pass_cnt++;
    ack_never = 1'b0;
    ack_wait  = 0;
    clear_obs();
    issue_cmd(1'b0, a, 2'd0, acc, ok);
    chk_cnt++; if (bus.err !== 1'b0) $display("FAIL timeout err_cleared: got %b want 0", bus.err); else pass_cnt++;
    wait_done(1, 50);
    repeat (2) step();
    chk_cnt++; if (last_err !== 1'b0) $display("FAIL after_timeout err: got %b want 0", last_err); else pass_cnt++;
    chk_cnt++; if (rdv_q.size() != 1 || rdv_q[0] !== ref_mem[a]) $display("FAIL after_timeout rdata: got %0d beats want 1 of %h", rdv_q.size(), ref_mem[a]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    int acc, budget;
    bit ok;
    logic [7:0] a, d0;
    a  = 8'($urandom);
    d0 = 8'($urandom);
    ack_wait  = 1;
    stall_gap = 0;
    repeat (6) step();
    clear_obs();
    wd_q.push_back(d0);
    for (int i = 1; i < 4; i++) wd_q.push_back(8'($urandom));
    issue_cmd(1'b1, a, 2'd3, acc, ok);
    budget = 50;
    while (!(wr_addr_q.size() == 1 && bus.mem_en) && budget > 0) begin
      step();
      budget--;
    end
    chk_cnt++; if (budget == 0) $display("FAIL reset_mid reach_beat2: got timeout want beat 2 active"); else pass_cnt++;
    reset = 1'b1;
    step();
    chk_cnt++; if ({bus.req_ready, bus.mem_en, bus.mem_we, bus.wdata_ready, bus.rdata_valid, bus.exec, bus.done, bus.err, bus.rd_wr} !== 9'h000)
      $display("FAIL reset_mid flags: got %b want 000000000", {bus.req_ready, bus.mem_en, bus.mem_we, bus.wdata_ready, bus.rdata_valid, bus.exec, bus.done, bus.err, bus.rd_wr}); else pass_cnt++;
    chk_cnt++; if ({bus.mem_addr, bus.mem_wdata, bus.rdata} !== 24'h0) $display("FAIL reset_mid buses: got %h want 000000", {bus.mem_addr, bus.mem_wdata, bus.rdata}); else pass_cnt++;
    wd_q.delete();
    step();
    reset = 1'b0;
    repeat (3) step();
    chk_cnt++; if (done_cyc_q.size() != 0) $display("FAIL reset_mid done_count: got %0d want 0", done_cyc_q.size()); else pass_cnt++;
    ref_mem[a] = d0;
    run_burst(1'b0, a, 2'd1, 0, 0, -1, "after_reset_read");
  endtask

  task automatic test_spurious_and_back_to_back();
    int acc1, acc2;
    bit ok1, ok2;
    logic [7:0] a1, a2;
    ack_wait = 0;
    repeat (4) step();
    clear_obs();
    spurious_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_cnt++; if (dbg_state !== ST_IDLE || bus.mem_en !== 1'b0 || bus.done !== 1'b0) $display("FAIL spurious_ack state: got %0d want 0", dbg_state); else pass_cnt++;
    end
    spurious_ack = 1'b0;
    step();
    chk_cnt++; if (rdv_q.size() != 0) $display("FAIL spurious_ack rdata_count: got %0d want 0", rdv_q.size()); else pass_cnt++;
    a1 = 8'($urandom);
    a2 = 8'($urandom);
    exp_q.delete();
    exp_q.push_back(ref_mem[a1]);
    exp_q.push_back(ref_mem[8'(a1 + 8'd1)]);
    exp_q.push_back(ref_mem[a2]);
    issue_cmd(1'b0, a1, 2'd1, acc1, ok1);
    issue_cmd(1'b0, a2, 2'd0, acc2, ok2);
    wait_done(2, 100);
    repeat (2) step();
    if (done_cyc_q.size() == 2) begin
      chk_cnt++; if (done_cyc_q[0] != acc1 + 4) $display("FAIL b2b done1_cycle: got %0d want %0d", done_cyc_q[0], acc1 + 4); else pass_cnt++;
      chk_cnt++; if (acc2 != done_cyc_q[0] + 1) $display("FAIL b2b accept2_cycle: got %0d want %0d", acc2, done_cyc_q[0] + 1); else pass_cnt++;
      chk_cnt++; if (done_cyc_q[1] != acc2 + 2) $display("FAIL b2b done2_cycle: got %0d want %0d", done_cyc_q[1], acc2 + 2); else pass_cnt++;
    end
    chk_cnt++; if (rdv_q.size() != 3) $display("FAIL b2b rdata_count: got %0d want 3", rdv_q.size()); else pass_cnt++;
    for (int i = 0; i < 3 && i < rdv_q.size(); i++) begin
      chk_cnt++; if (rdv_q[i] !== exp_q[i]) $display("FAIL b2b rdata[%0d]: got %h want %h", i, rdv_q[i], exp_q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_random_bursts();
    for (int n = 0; n < 16; n++) begin
      run_burst(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom_range(0, 3)),
                $urandom_range(0, 3), $urandom_range(0, 3), -1, "random");
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 8'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    test_reset();
    test_write_burst();
    test_read_wrap();
    test_write_stall();
    test_single_read();
    test_timeout();
    test_reset_mid_burst();
    test_spurious_and_back_to_back();
    test_random_bursts();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
